packet_tx_framer: RTL and testbench

PACKET_TX_FRAMER -- requirements
Module: packet_tx_framer

---
 rtl/packet_pkg.sv | 31 +++
 rtl/tx_fifo.sv | 61 ++++++
 rtl/packet_tx_framer.sv | 153 +++++++++++++++
 tb/tb_packet_tx_framer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// Shared types and helpers for the packet transmit framer.
// Packets are two 16-bit halves packed into one 32-bit channel word.
package packet_pkg;

    localparam int unsigned PKT_W  = 32;
    localparam int unsigned NODE_W = 16;

    localparam logic [PKT_W-1:0] IDLE_PKT = '0;

    typedef enum logic [2:0] {
        IDLE,
        CTRL,
        GAP,
        DATA,
        TAIL
    } tx_state_t;

    function automatic logic [PKT_W-1:0] pack16(input logic [NODE_W-1:0] hi,
                                                input logic [NODE_W-1:0] lo);
        return {hi, lo};
    endfunction

    function automatic logic [NODE_W-1:0] pkt_hi(input logic [PKT_W-1:0] pkt);
        return pkt[PKT_W-1:NODE_W];
    endfunction

    function automatic logic [NODE_W-1:0] pkt_lo(input logic [PKT_W-1:0] pkt);
        return pkt[NODE_W-1:0];
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous payload FIFO with occupancy count; DEPTH must be a power of two.
// Writes when full and reads when empty are dropped.
module tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic [AW:0]      count
);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_fire, rd_fire;

    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && (count_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (wr_fire && !rd_fire) begin
                count_q <= count_q + CNT_ONE;
            end else if (rd_fire && !wr_fire) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/packet_tx_framer.sv
// Frames buffered payload words into a control word, a gap, a data burst and a tail.
// Requests are validated against the network size and buffered payload before launch.
module packet_tx_framer
    import packet_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NODE_W-1:0] node_id,
    input  logic [NODE_W-1:0] max_node,
    input  logic              wr_valid,
    input  logic [NODE_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              send_valid,
    input  logic [NODE_W-1:0] send_dest,
    input  logic [NODE_W-1:0] send_len,
    output logic              send_ready,
    output logic [PKT_W-1:0]  control_tx_packet,
    output logic [PKT_W-1:0]  data_tx_packet,
    output logic              done,
    output logic              err
);

    localparam int unsigned       CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [NODE_W-1:0] LEN_MAX = NODE_W'(FIFO_DEPTH);
    localparam logic [NODE_W-1:0] LEN_ONE = NODE_W'(1);

    tx_state_t         state_q, state_d;
    logic [NODE_W-1:0] dest_q, dest_d;
    logic [NODE_W-1:0] len_q, len_d;
    logic [NODE_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              live_q;

    logic              pop;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;
    logic [NODE_W-1:0] fifo_head;
    logic [NODE_W-1:0] fifo_level;

    logic signed [NODE_W-1:0] dest_s, max_s;
    logic              accept, req_ok;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NODE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_valid && wr_ready),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // live_q keeps both ready outputs low through reset and for the release cycle.
    assign wr_ready   = live_q && !fifo_full;
    assign send_ready = live_q && (state_q == IDLE);
    assign accept     = send_valid && send_ready;

    assign fifo_level = NODE_W'(fifo_count);
    assign dest_s     = send_dest;
    assign max_s      = max_node;

    // Node ids are signed; the length is unsigned.
    assign req_ok = (dest_s > 16'sd0) &&
                    (dest_s < max_s) &&
                    (send_dest != node_id) &&
                    (node_id != '0) &&
                    (send_len != '0) &&
                    (send_len <= LEN_MAX) &&
                    (fifo_level >= send_len);

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_ok) begin
                        dest_d  = send_dest;
                        len_d   = send_len;
                        state_d = CTRL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CTRL: begin
                state_d = GAP;
            end
            GAP: begin
                cnt_d   = len_q;
                state_d = DATA;
            end
            DATA: begin
                pop = 1'b1;
                if (cnt_q == LEN_ONE) begin
                    state_d = TAIL;
                end else begin
                    cnt_d = cnt_q - LEN_ONE;
                end
            end
            TAIL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dest_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    always_comb begin
        control_tx_packet = IDLE_PKT;
        data_tx_packet    = IDLE_PKT;
        if (state_q == CTRL) begin
            control_tx_packet = pack16(dest_q, len_q);
        end
        if (state_q == DATA) begin
            data_tx_packet = pack16(node_id, fifo_head);
        end
    end

    assign done = (state_q == TAIL);
    assign err  = err_q;

endmodule

// File: tb/tb_packet_tx_framer.sv
// Directed self-checking bench for packet_tx_framer (node 1 on a 4-node network).
module tb_packet_tx_framer;
    import packet_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] node_id, max_node, wr_data, send_dest, send_len;
    logic        wr_valid, wr_ready, send_valid, send_ready, done, err;
    logic [31:0] control_tx_packet, data_tx_packet;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] obs_ctrl [0:15];
    logic [31:0] obs_data [0:15];
    logic        obs_done [0:15];
    logic        obs_err  [0:15];
    logic        obs_srdy [0:15];

    always #5 clk = ~clk;

    packet_tx_framer #(.FIFO_DEPTH(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .node_id           (node_id),
        .max_node          (max_node),
        .wr_valid          (wr_valid),
        .wr_data           (wr_data),
        .wr_ready          (wr_ready),
        .send_valid        (send_valid),
        .send_dest         (send_dest),
        .send_len          (send_len),
        .send_ready        (send_ready),
        .control_tx_packet (control_tx_packet),
        .data_tx_packet    (data_tx_packet),
        .done              (done),
        .err               (err)
    );

    // Stimulus helpers: always entered and left on a falling edge.
    task automatic write_word(input logic [15:0] w);
        wr_valid = 1'b1;
        wr_data  = w;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic request(input logic [15:0] d, input logic [15:0] l, input int n);
        obs_srdy[0] = send_ready;
        send_valid  = 1'b1;
        send_dest   = d;
        send_len    = l;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            send_valid  = 1'b0;
            obs_ctrl[k] = control_tx_packet;
            obs_data[k] = data_tx_packet;
            obs_done[k] = done;
            obs_err[k]  = err;
            obs_srdy[k] = send_ready;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (send_ready !== 1'b0 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready got s=%b w=%b want 0 0", send_ready, wr_ready);
        end
        n_tests++;
        if (control_tx_packet !== 32'h0 || data_tx_packet !== 32'h0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got c=%h d=%h done=%b err=%b want zeros",
                     control_tx_packet, data_tx_packet, done, err);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (send_ready !== 1'b0 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL release_ready_early got s=%b w=%b want 0 0", send_ready, wr_ready);
        end
        @(negedge clk);
        n_tests++;
        if (send_ready !== 1'b1 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready got s=%b w=%b want 1 1", send_ready, wr_ready);
        end
    endtask

    task automatic test_basic;
        logic [31:0] ec, ed;
        for (int i = 0; i < 4; i++) write_word(16'h000A + 16'(i));
        request(16'd2, 16'd4, 8);
        n_tests++;
        if (obs_srdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_send_ready got %b want 1", obs_srdy[0]);
        end
        for (int k = 1; k <= 8; k++) begin
            ec = (k == 1) ? 32'h0002_0004 : 32'h0;
            ed = (k >= 3 && k <= 6) ? {16'h0001, 16'h000A + 16'(k - 3)} : 32'h0;
            n_tests++;
            if (obs_ctrl[k] !== ec || obs_data[k] !== ed) begin
                n_fail++;
                $display("FAIL basic_pkt k=%0d got c=%h d=%h want c=%h d=%h",
                         k, obs_ctrl[k], obs_data[k], ec, ed);
            end
            n_tests++;
            if (obs_done[k] !== (k == 7) || obs_err[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_done k=%0d got done=%b err=%b want done=%b err=0",
                         k, obs_done[k], obs_err[k], (k == 7));
            end
        end
        n_tests++;
        if (obs_srdy[8] !== 1'b1 || obs_srdy[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ready_busy got k3=%b k8=%b want 0 1", obs_srdy[3], obs_srdy[8]);
        end
    endtask

    task automatic test_reject;
        logic [15:0] bad_dest [4];
        logic [15:0] bad_len  [4];
        bad_dest = '{16'd1, 16'd4, 16'd0, 16'd2};
        bad_len  = '{16'd4, 16'd4, 16'd4, 16'd0};
        for (int i = 0; i < 4; i++) write_word(16'h0B00 + 16'(i));
        for (int r = 0; r < 4; r++) begin
            request(bad_dest[r], bad_len[r], 4);
            n_tests++;
            if (obs_err[1] !== 1'b1 || obs_err[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL reject_err r=%0d got %b%b want 10", r, obs_err[1], obs_err[2]);
            end
            for (int k = 1; k <= 4; k++) begin
                n_tests++;
                if (obs_ctrl[k] !== 32'h0 || obs_data[k] !== 32'h0 || obs_done[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reject_quiet r=%0d k=%0d got c=%h d=%h done=%b want 0",
                             r, k, obs_ctrl[k], obs_data[k], obs_done[k]);
                end
            end
        end
        // FIFO must still hold exactly the four words.
        request(16'd3, 16'd4, 8);
        for (int k = 3; k <= 6; k++) begin
            n_tests++;
            if (obs_data[k] !== {16'h0001, 16'h0B00 + 16'(k - 3)}) begin
                n_fail++;
                $display("FAIL reject_keep k=%0d got %h want %h", k, obs_data[k],
                         {16'h0001, 16'h0B00 + 16'(k - 3)});
            end
        end
        n_tests++;
        if (obs_done[7] !== 1'b1 || obs_ctrl[1] !== 32'h0003_0004) begin
            n_fail++;
            $display("FAIL reject_keep_frame got done=%b c=%h want 1 00030004", obs_done[7], obs_ctrl[1]);
        end
    endtask

    task automatic test_short;
        write_word(16'h0011);
        write_word(16'h0022);
        request(16'd2, 16'd4, 3);
        n_tests++;
        if (obs_err[1] !== 1'b1 || obs_ctrl[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL short_err got err=%b c=%h want 1 0", obs_err[1], obs_ctrl[1]);
        end
        write_word(16'h0033);
        write_word(16'h0044);
        request(16'd3, 16'd4, 8);
        n_tests++;
        if (obs_ctrl[1] !== 32'h0003_0004 || obs_err[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL short_retry_ctrl got c=%h err=%b want 00030004 0", obs_ctrl[1], obs_err[1]);
        end
        for (int k = 3; k <= 6; k++) begin
            n_tests++;
            if (obs_data[k] !== {16'h0001, 16'h0011 * 16'(k - 2)}) begin
                n_fail++;
                $display("FAIL short_retry_data k=%0d got %h want %h", k, obs_data[k],
                         {16'h0001, 16'h0011 * 16'(k - 2)});
            end
        end
        n_tests++;
        if (obs_done[7] !== 1'b1 || obs_data[7] !== 32'h0) begin
            n_fail++;
            $display("FAIL short_retry_tail got done=%b d=%h want 1 0", obs_done[7], obs_data[7]);
        end
    endtask

    task automatic test_full;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (wr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL full_fill_ready i=%0d got %b want 1", i, wr_ready);
            end
            write_word(16'h0100 + 16'(i));
        end
        n_tests++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready got %b want 0", wr_ready);
        end
        write_word(16'hDEAD);
        request(16'd2, 16'd9, 3);
        n_tests++;
        if (obs_err[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL full_len9 got err=%b want 1", obs_err[1]);
        end
        request(16'd2, 16'd8, 12);
        n_tests++;
        if (obs_ctrl[1] !== 32'h0002_0008) begin
            n_fail++;
            $display("FAIL full_ctrl got %h want 00020008", obs_ctrl[1]);
        end
        for (int k = 3; k <= 11; k++) begin
            n_tests++;
            if (obs_data[k] !== ((k <= 10) ? {16'h0001, 16'h0100 + 16'(k - 3)} : 32'h0)) begin
                n_fail++;
                $display("FAIL full_data k=%0d got %h", k, obs_data[k]);
            end
        end
        n_tests++;
        if (obs_done[11] !== 1'b1 || obs_done[10] !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done got k10=%b k11=%b want 0 1", obs_done[10], obs_done[11]);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) write_word(16'h0201 + 16'(i));
        request(16'd2, 16'd4, 4);
        n_tests++;
        if (obs_data[4] !== 32'h0001_0202) begin
            n_fail++;
            $display("FAIL mid_pre got %h want 00010202", obs_data[4]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (control_tx_packet !== 32'h0 || data_tx_packet !== 32'h0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_outputs got c=%h d=%h done=%b err=%b want zeros",
                     control_tx_packet, data_tx_packet, done, err);
        end
        n_tests++;
        if (send_ready !== 1'b0 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ready got s=%b w=%b want 0 0", send_ready, wr_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || data_tx_packet !== 32'h0) begin
                n_fail++;
                $display("FAIL mid_after k=%0d got done=%b d=%h want 0 0", k, done, data_tx_packet);
            end
        end
        // An empty FIFO rejects even a one-word message.
        request(16'd2, 16'd1, 4);
        n_tests++;
        if (obs_err[1] !== 1'b1 || obs_ctrl[1] !== 32'h0 || obs_data[3] !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_empty got err=%b c=%h d=%h want 1 0 0", obs_err[1], obs_ctrl[1], obs_data[3]);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) write_word(16'h0301 + 16'(i));
        obs_srdy[0] = send_ready;
        send_valid  = 1'b1;
        send_dest   = 16'd2;
        send_len    = 16'd4;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            send_valid  = 1'b0;
            obs_data[k] = data_tx_packet;
            obs_done[k] = done;
            wr_valid    = (k >= 3 && k <= 6);
            wr_data     = 16'h0401 + 16'(k - 3);
        end
        wr_valid = 1'b0;
        for (int k = 3; k <= 6; k++) begin
            n_tests++;
            if (obs_data[k] !== {16'h0001, 16'h0301 + 16'(k - 3)}) begin
                n_fail++;
                $display("FAIL b2b_first k=%0d got %h want %h", k, obs_data[k],
                         {16'h0001, 16'h0301 + 16'(k - 3)});
            end
        end
        n_tests++;
        if (obs_done[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_done got %b want 1", obs_done[7]);
        end
        request(16'd3, 16'd4, 8);
        for (int k = 3; k <= 6; k++) begin
            n_tests++;
            if (obs_data[k] !== {16'h0001, 16'h0401 + 16'(k - 3)}) begin
                n_fail++;
                $display("FAIL b2b_second k=%0d got %h want %h", k, obs_data[k],
                         {16'h0001, 16'h0401 + 16'(k - 3)});
            end
        end
        request(16'd2, 16'd1, 3);
        n_tests++;
        if (obs_err[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_drained got err=%b want 1", obs_err[1]);
        end
    endtask

    initial begin
        node_id    = 16'd1;
        max_node   = 16'd4;
        wr_valid   = 1'b0;
        wr_data    = 16'h0;
        send_valid = 1'b0;
        send_dest  = 16'h0;
        send_len   = 16'h0;
        test_reset();
        test_basic();
        test_reject();
        test_short();
        test_full();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
